// File: rtl/conv_seq_pkg.sv
// Shared widths, FSM encoding and index-bound helpers for the convolution sequencer.
// The bound functions are shared so the index generator and its users agree on term ranges.
package conv_seq_pkg;

  localparam int SIZE_W   = 5;
  localparam int ZADDR_W  = 6;
  localparam int PIPE_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  typedef logic [ZADDR_W-1:0] idx_t;

  // Smallest k whose Y index n-k still lands inside the signal.
  function automatic idx_t k_lo_f(input idx_t n, input idx_t sy);
    return (n >= sy) ? idx_t'(n - sy + idx_t'(1)) : '0;
  endfunction

  function automatic idx_t k_hi_f(input idx_t n, input idx_t sx);
    idx_t top;
    top = sx - idx_t'(1);
    return (n < top) ? n : top;
  endfunction

endpackage

// File: rtl/convolution_sequencer_if.sv
// Control/address bundle between the convolution sequencer and the datapath/host.
// master is the sequencer side, slave is the MAC/memory/host side.
interface convolution_sequencer_if;
  import conv_seq_pkg::*;

  logic              start;
  logic [SIZE_W-1:0] size_x;
  logic [SIZE_W-1:0] size_y;
  logic [SIZE_W-1:0] x_addr;
  logic [SIZE_W-1:0] y_addr;
  logic              mac_en;
  logic              mac_clr;
  idx_t              z_addr;
  logic              z_we;
  idx_t              z_len;
  logic              busy;
  logic              done;

  modport master (
    input  start, size_x, size_y,
    output x_addr, y_addr, mac_en, mac_clr, z_addr, z_we, z_len, busy, done
  );

  modport slave (
    output start, size_x, size_y,
    input  x_addr, y_addr, mac_en, mac_clr, z_addr, z_we, z_len, busy, done
  );

endinterface

// File: rtl/conv_index_gen.sv
// n/k term walker: steps through every valid (n, k) pair of the linear convolution
// and flags the first, last and final term of each output index.
module conv_index_gen
  import conv_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_a,
  input  logic              load,
  input  logic              step,
  input  logic [SIZE_W-1:0] size_x,
  input  logic [SIZE_W-1:0] size_y,
  output logic [SIZE_W-1:0] x_addr,
  output logic [SIZE_W-1:0] y_addr,
  output idx_t              n_idx,
  output logic              first_term,
  output logic              last_term,
  output logic              final_term
);

  idx_t n_q;
  idx_t k_q;
  idx_t sx;
  idx_t sy;
  idx_t n_inc;
  idx_t lo_cur;
  idx_t hi_cur;
  idx_t lo_nxt;
  idx_t n_last;

  assign sx     = idx_t'(size_x);
  assign sy     = idx_t'(size_y);
  assign n_inc  = n_q + idx_t'(1);
  assign lo_cur = k_lo_f(n_q, sy);
  assign hi_cur = k_hi_f(n_q, sx);
  assign lo_nxt = k_lo_f(n_inc, sy);
  assign n_last = sx + sy - idx_t'(2);

  assign first_term = (k_q == lo_cur);
  assign last_term  = (k_q == hi_cur);
  assign final_term = last_term && (n_q == n_last);

  assign n_idx  = n_q;
  assign x_addr = SIZE_W'(k_q);
  assign y_addr = SIZE_W'(n_q - k_q);

  // On the last term of n, jump straight to the first valid k of n+1 so no cycle is wasted.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      n_q <= '0;
      k_q <= '0;
    end else if (load) begin
      n_q <= '0;
      k_q <= '0;
    end else if (step) begin
      if (last_term) begin
        n_q <= n_inc;
        k_q <= lo_nxt;
      end else begin
        k_q <= k_q + idx_t'(1);
      end
    end
  end

endmodule

// File: rtl/convolution_sequencer.sv
// Convolution control FSM: issues X/Y reads, aligns MAC and Z-write strobes to the
// memory read latency, and pulses done when the last result has been written.
module convolution_sequencer
  import conv_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_a,
  input  logic                    en_s,
  convolution_sequencer_if.master bus
);

  localparam int DRAIN_W = $clog2(PIPE_LAT + 2);

  state_t              state_q;
  state_t              state_d;
  logic [SIZE_W-1:0]   size_x_q;
  logic [SIZE_W-1:0]   size_y_q;
  idx_t                z_len_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic                accept;
  logic                zero_size;
  logic                issuing;
  logic                step;
  logic [SIZE_W-1:0]   x_idx;
  logic [SIZE_W-1:0]   y_idx;
  idx_t                n_idx;
  logic                first_term;
  logic                last_term;
  logic                final_term;
  logic [PIPE_LAT-1:0] v_pipe;
  logic [PIPE_LAT-1:0] first_pipe;
  logic [PIPE_LAT-1:0] last_pipe;
  idx_t                n_pipe [PIPE_LAT];
  logic                we_q;
  idx_t                z_addr_q;
  logic                mac_raw;
  logic                busy_c;
  logic                done_c;

  assign accept    = (state_q == IDLE) && bus.start && en_s;
  assign zero_size = (bus.size_x == '0) || (bus.size_y == '0);
  assign issuing   = (state_q == ISSUE);
  assign step      = issuing && en_s;

  conv_index_gen u_index_gen (
    .clk        (clk),
    .rst_a      (rst_a),
    .load       (accept),
    .step       (step),
    .size_x     (size_x_q),
    .size_y     (size_y_q),
    .x_addr     (x_idx),
    .y_addr     (y_idx),
    .n_idx      (n_idx),
    .first_term (first_term),
    .last_term  (last_term),
    .final_term (final_term)
  );

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = zero_size ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        busy_c = 1'b1;
        if (en_s && final_term) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (en_s && (drain_q == DRAIN_W'(PIPE_LAT))) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_c = en_s;
        if (en_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sizes are captured once so later pin activity cannot disturb a running walk.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      size_x_q <= '0;
      size_y_q <= '0;
      z_len_q  <= '0;
    end else if (accept) begin
      size_x_q <= bus.size_x;
      size_y_q <= bus.size_y;
      z_len_q  <= zero_size ? '0
                            : idx_t'(bus.size_x) + idx_t'(bus.size_y) - idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      drain_q <= '0;
    end else if (en_s) begin
      drain_q <= (state_q == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
    end
  end

  // Issue flags ride PIPE_LAT stages to meet the read data, then one more stage for the
  // accumulator register before the Z write; the whole pipe freezes with en_s.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      v_pipe     <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        n_pipe[i] <= '0;
      end
      we_q     <= 1'b0;
      z_addr_q <= '0;
    end else if (en_s) begin
      v_pipe[0]     <= issuing;
      first_pipe[0] <= first_term;
      last_pipe[0]  <= last_term;
      n_pipe[0]     <= n_idx;
      for (int i = 1; i < PIPE_LAT; i++) begin
        v_pipe[i]     <= v_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
        n_pipe[i]     <= n_pipe[i-1];
      end
      we_q     <= v_pipe[PIPE_LAT-1] && last_pipe[PIPE_LAT-1];
      z_addr_q <= n_pipe[PIPE_LAT-1];
    end
  end

  assign mac_raw = v_pipe[PIPE_LAT-1] && en_s;

  assign bus.x_addr  = issuing ? x_idx : '0;
  assign bus.y_addr  = issuing ? y_idx : '0;
  assign bus.mac_en  = mac_raw;
  assign bus.mac_clr = mac_raw && first_pipe[PIPE_LAT-1];
  assign bus.z_we    = we_q && en_s;
  assign bus.z_addr  = z_addr_q;
  assign bus.z_len   = z_len_q;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;

endmodule

// File: tb/tb_convolution_sequencer.sv
// Randomized bench for convolution_sequencer: a per-enabled-cycle expected trace is built
// by enumerating convolution terms directly and compared against the DUT every cycle.
module tb_convolution_sequencer;
  import conv_seq_pkg::*;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic en_s  = 1'b0;

  convolution_sequencer_if bus();

  convolution_sequencer dut (
    .clk   (clk),
    .rst_a (rst_a),
    .en_s  (en_s),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit issue;
    int x;
    int y;
    bit mac_en;
    bit mac_clr;
    bit z_we;
    int z_addr;
    bit done;
    bit busy;
  } cyc_t;

  localparam int TR_MAX = 1024;

  cyc_t tr [TR_MAX];
  int   trace_len;
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Expected trace indexed by enabled cycle after the start edge: reads for each valid
  // (n,k) in order, MAC one cycle later, Z write two cycles after the last term of n.
  task automatic buildTrace(input int sx, input int sy);
    int idx;
    int last_idx;
    bit first;
    for (int i = 0; i < TR_MAX; i++) begin
      tr[i].issue = 0; tr[i].x = 0; tr[i].y = 0;
      tr[i].mac_en = 0; tr[i].mac_clr = 0; tr[i].z_we = 0;
      tr[i].z_addr = 0; tr[i].done = 0; tr[i].busy = 0;
    end
    if (sx == 0 || sy == 0) begin
      trace_len = 1;
      tr[1].done = 1;
    end else begin
      idx = 0;
      for (int n = 0; n <= sx + sy - 2; n++) begin
        first = 1;
        last_idx = 0;
        for (int k = 0; k < sx; k++) begin
          if (n - k >= 0 && n - k < sy) begin
            idx++;
            tr[idx].issue       = 1;
            tr[idx].x           = k;
            tr[idx].y           = n - k;
            tr[idx+1].mac_en    = 1;
            tr[idx+1].mac_clr   = first;
            first               = 0;
            last_idx            = idx;
          end
        end
        tr[last_idx+2].z_we   = 1;
        tr[last_idx+2].z_addr = n;
      end
      for (int i = 1; i <= idx + 2; i++) tr[i].busy = 1;
      tr[idx+3].done = 1;
      trace_len = idx + 3;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".x_addr"},  int'(bus.x_addr),  0);
    checkOutput({tag, ".y_addr"},  int'(bus.y_addr),  0);
    checkOutput({tag, ".mac_en"},  int'(bus.mac_en),  0);
    checkOutput({tag, ".mac_clr"}, int'(bus.mac_clr), 0);
    checkOutput({tag, ".z_we"},    int'(bus.z_we),    0);
    checkOutput({tag, ".z_addr"},  int'(bus.z_addr),  0);
    checkOutput({tag, ".z_len"},   int'(bus.z_len),   0);
    checkOutput({tag, ".busy"},    int'(bus.busy),    0);
    checkOutput({tag, ".done"},    int'(bus.done),    0);
  endtask

  task automatic applyStimulus(input int sx, input int sy, input int stall_at,
                               input int stall_len, input int rand_pct, input bit probe_start);
    int j, guard, budget, stall_left, mac_cnt, we_cnt, exp_len;
    bit stalled, en;
    string t;
    buildTrace(sx, sy);
    exp_len = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
    budget  = 4 * trace_len + stall_len + 50;

    @(posedge clk); #1;
    en_s = 1'b1; bus.start = 1'b1;
    bus.size_x = SIZE_W'(sx); bus.size_y = SIZE_W'(sy);
    @(negedge clk);
    checkOutput($sformatf("%0dx%0d.idle_busy", sx, sy), int'(bus.busy), 0);

    j = 0; guard = 0; stall_left = 0; stalled = 0; mac_cnt = 0; we_cnt = 0;
    while (j < trace_len && guard < budget) begin
      @(posedge clk); #1;
      bus.start  = probe_start && (j == 3);
      bus.size_x = SIZE_W'($urandom);
      bus.size_y = SIZE_W'($urandom);
      if (stall_left > 0) begin
        en = 0; stall_left--;
      end else if (j == stall_at && !stalled) begin
        en = 0; stalled = 1; stall_left = stall_len - 1;
      end else begin
        en = ($urandom_range(99) >= rand_pct);
      end
      en_s = en;
      @(negedge clk);
      guard++;
      t = $sformatf("%0dx%0d@%0d", sx, sy, j + 1);
      if (en) begin
        j++;
        checkOutput({t, ".mac_en"},  int'(bus.mac_en),  int'(tr[j].mac_en));
        checkOutput({t, ".mac_clr"}, int'(bus.mac_clr), int'(tr[j].mac_clr));
        checkOutput({t, ".z_we"},    int'(bus.z_we),    int'(tr[j].z_we));
        checkOutput({t, ".done"},    int'(bus.done),    int'(tr[j].done));
        checkOutput({t, ".busy"},    int'(bus.busy),    int'(tr[j].busy));
        if (tr[j].issue) begin
          checkOutput({t, ".x_addr"}, int'(bus.x_addr), tr[j].x);
          checkOutput({t, ".y_addr"}, int'(bus.y_addr), tr[j].y);
        end
        if (tr[j].z_we) checkOutput({t, ".z_addr"}, int'(bus.z_addr), tr[j].z_addr);
        if (j == 1) checkOutput({t, ".z_len"}, int'(bus.z_len), exp_len);
        if (bus.mac_en) mac_cnt++;
        if (bus.z_we)   we_cnt++;
      end else begin
        checkOutput({t, ".stall_mac_en"},  int'(bus.mac_en),  0);
        checkOutput({t, ".stall_mac_clr"}, int'(bus.mac_clr), 0);
        checkOutput({t, ".stall_z_we"},    int'(bus.z_we),    0);
        checkOutput({t, ".stall_done"},    int'(bus.done),    0);
        checkOutput({t, ".stall_busy"},    int'(bus.busy),    int'(tr[j+1].busy));
      end
    end
    if (j < trace_len) checkOutput($sformatf("%0dx%0d.timeout", sx, sy), j, trace_len);

    @(posedge clk); #1;
    en_s = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    t = $sformatf("%0dx%0d.after", sx, sy);
    checkOutput({t, ".done"},    int'(bus.done),   0);
    checkOutput({t, ".busy"},    int'(bus.busy),   0);
    checkOutput({t, ".mac_en"},  int'(bus.mac_en), 0);
    checkOutput({t, ".z_we"},    int'(bus.z_we),   0);
    checkOutput({t, ".z_len"},   int'(bus.z_len),  exp_len);
    checkOutput({t, ".mac_cnt"}, mac_cnt, sx * sy);
    checkOutput({t, ".we_cnt"},  we_cnt,  exp_len);
  endtask

  task automatic resetMidRun();
    @(posedge clk); #1;
    en_s = 1'b1; bus.start = 1'b1; bus.size_x = 5'd4; bus.size_y = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst.pre_x_addr", int'(bus.x_addr), 1);
    checkOutput("rst.pre_y_addr", int'(bus.y_addr), 0);
    checkOutput("rst.pre_busy",   int'(bus.busy),   1);
    rst_a = 1'b0;
    #1;
    checkAllZero("rst.mid");
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst.hold_done", int'(bus.done), 0);
      checkOutput("rst.hold_busy", int'(bus.busy), 0);
    end
    @(posedge clk); #1;
    rst_a = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst.post_done", int'(bus.done), 0);
      checkOutput("rst.post_busy", int'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.size_x = '0;
    bus.size_y = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst_a = 1'b1;

    applyStimulus(3, 2, -1, 0, 0, 1'b0);
    applyStimulus(1, 1, -1, 0, 0, 1'b0);
    applyStimulus(31, 31, -1, 0, 0, 1'b0);
    applyStimulus(0, 5, -1, 0, 0, 1'b0);
    applyStimulus(5, 0, -1, 0, 0, 1'b0);
    applyStimulus(4, 4, 6, 5, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      applyStimulus(int'($urandom_range(12)), int'($urandom_range(12)), -1, 0, 20, 1'b1);
    end

    resetMidRun();
    applyStimulus(2, 3, -1, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
